// File: rtl/fe_mont_exp.sv
// fe_mont_exp: modular exponentiation y = x^e mod p, p = 2^255 - 19.
// Left-to-right square-and-multiply carried out in the Montgomery domain
// (R = 2^255). Every multiplication is delegated to an external radix-2
// Montgomery multiplier through the mm_* handshake.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         one-cycle request, sampled only while idle
//   x, e          base (< p) and exponent, captured on an accepted start
//   busy, done    busy from the cycle after start until done; done pulses once
//   y             fully reduced result, held until the next accepted start
//   mm_a, mm_b    registered multiplier operands
//   mm_rst        multiplier load strobe (one cycle per multiplication)
//   mm_out        multiplier result a*b*2^-255 mod p (may be >= p)
//   mm_done       multiplier completion pulse
//
// Build option: define MONT_EXP_CT_EN for a constant-time schedule, in which
// the multiply step runs for every exponent bit and the result of a
// zero-bit multiply is discarded into a dummy slot.
module fe_mont_exp #(
   parameter int EXP_W = 255,
   parameter int FE_W  = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [FE_W-1:0]  x,
   input  logic [EXP_W-1:0] e,
   output logic             busy,
   output logic             done,
   output logic [FE_W-1:0]  y,
   output logic [FE_W-1:0]  mm_a,
   output logic [FE_W-1:0]  mm_b,
   output logic             mm_rst,
   input  logic [FE_W-1:0]  mm_out,
   input  logic             mm_done
);

   localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;
   localparam logic [FE_W-1:0] P      = {FE_W{1'b1}} - FE_W'(18);
   localparam logic [FE_W-1:0] ONE_M  = FE_W'(19);   // R mod p
   localparam logic [FE_W-1:0] R2     = FE_W'(361);  // R^2 mod p
   localparam logic [FE_W-1:0] FE_ONE = FE_W'(1);

   typedef enum logic [2:0] {IDLE, TOM, SQR, MUL, NEXT, FROM, FIN} state_t;

   state_t          state_r, state_s;
   logic            waiting_r, waiting_s;   // 0 in the load cycle of a multiply
   logic [EXP_W-1:0] e_r, e_s;
   logic [IW-1:0]   i_r, i_s;
   // Slot 1 is the accumulator; slot 0 only ever receives discarded
   // multiply results in the constant-time build.
   logic [FE_W-1:0] acc_r [2];
   logic [FE_W-1:0] acc_s [2];
   logic [FE_W-1:0] xm_r, xm_s;
   logic [FE_W-1:0] res_r, res_s;
   logic            busy_s, done_s, mm_rst_s;
   logic [FE_W-1:0] y_s, mm_a_s, mm_b_s;
   logic            ld_s;
   logic [FE_W-1:0] ld_a_s, ld_b_s;
   logic            step_done_s, e_bit_s;

   // mm_done only counts once the load cycle has passed
   assign step_done_s = waiting_r & mm_done;
   assign e_bit_s     = e_r[i_r];

   // Next-state and datapath decisions for the sequencer
   always_comb begin
      state_s   = state_r;
      waiting_s = 1'b1;
      e_s       = e_r;
      i_s       = i_r;
      acc_s     = acc_r;
      xm_s      = xm_r;
      res_s     = res_r;
      busy_s    = busy;
      done_s    = 1'b0;
      y_s       = y;
      mm_a_s    = mm_a;
      mm_b_s    = mm_b;
      mm_rst_s  = 1'b0;
      ld_s      = 1'b0;
      ld_a_s    = acc_r[1];
      ld_b_s    = acc_r[1];
      case (state_r)
         IDLE: begin
            if (start) begin
               e_s      = e;
               i_s      = IW'(EXP_W - 1);
               acc_s[1] = ONE_M;
               busy_s   = 1'b1;
               state_s  = TOM;
               ld_s     = 1'b1;
               ld_a_s   = x;
               ld_b_s   = R2;
            end else begin
               state_s = IDLE;
            end
         end
         TOM: begin
            if (step_done_s) begin
               xm_s    = mm_out;
               state_s = SQR;
               ld_s    = 1'b1;
            end else begin
               state_s = TOM;
            end
         end
         SQR: begin
            if (step_done_s) begin
               acc_s[1] = mm_out;
               ld_a_s   = mm_out;
               ld_b_s   = xm_r;
`ifdef MONT_EXP_CT_EN
               state_s  = MUL;
               ld_s     = 1'b1;
`else
               if (e_bit_s) begin
                  state_s = MUL;
                  ld_s    = 1'b1;
               end else begin
                  state_s = NEXT;
               end
`endif
            end else begin
               state_s = SQR;
            end
         end
         MUL: begin
            if (step_done_s) begin
`ifdef MONT_EXP_CT_EN
               acc_s[e_bit_s] = mm_out;
`else
               acc_s[1] = mm_out;
`endif
               state_s = NEXT;
            end else begin
               state_s = MUL;
            end
         end
         NEXT: begin
            ld_s = 1'b1;
            if (i_r == IW'(0)) begin
               state_s = FROM;
               ld_b_s  = FE_ONE;
            end else begin
               i_s     = i_r - IW'(1);
               state_s = SQR;
            end
         end
         FROM: begin
            if (step_done_s) begin
               res_s   = mm_out;
               state_s = FIN;
            end else begin
               state_s = FROM;
            end
         end
         FIN: begin
            // Multiplier output lies in [0, 2^255), so one subtraction suffices
            y_s     = (res_r >= P) ? (res_r - P) : res_r;
            done_s  = 1'b1;
            busy_s  = 1'b0;
            state_s = IDLE;
         end
         default: begin
            busy_s  = 1'b0;
            state_s = IDLE;
         end
      endcase
      if (ld_s) begin
         mm_a_s    = ld_a_s;
         mm_b_s    = ld_b_s;
         mm_rst_s  = 1'b1;
         waiting_s = 1'b0;
      end else begin
         mm_rst_s = 1'b0;
      end
   end

   // State, datapath and registered outputs; reset holds the multiplier in reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         waiting_r <= 1'b0;
         e_r       <= '0;
         i_r       <= '0;
         acc_r[0]  <= '0;
         acc_r[1]  <= '0;
         xm_r      <= '0;
         res_r     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         y         <= '0;
         mm_a      <= '0;
         mm_b      <= '0;
         mm_rst    <= 1'b1;
      end else begin
         state_r   <= state_s;
         waiting_r <= waiting_s;
         e_r       <= e_s;
         i_r       <= i_s;
         acc_r     <= acc_s;
         xm_r      <= xm_s;
         res_r     <= res_s;
         busy      <= busy_s;
         done      <= done_s;
         y         <= y_s;
         mm_a      <= mm_a_s;
         mm_b      <= mm_b_s;
         mm_rst    <= mm_rst_s;
      end
   end

endmodule

// File: tb/tb_fe_mont_exp.sv
// Self-checking bench for fe_mont_exp. A behavioural Montgomery multiplier
// answers the mm_* handshake after a random delay; expected results come
// from plain modular exponentiation over 512-bit arithmetic.
module tb_fe_mont_exp;

   localparam logic [254:0] P = {255{1'b1}} - 255'd18;
   localparam int BUDGET = 40000;

   logic         clk = 1'b0;
   logic         rst, start;
   logic [254:0] x_in, e_in;
   logic         busy, done, mm_rst, mm_done;
   logic [254:0] y, mm_a, mm_b, mm_out;

   int n_cmp = 0;
   int n_bad = 0;
   int pulses = 0;
   int dmin = 1;
   int dmax = 4;
   int long_left = 0;
   logic [254:0] rinv;

   fe_mont_exp dut (
      .clk(clk), .rst(rst), .start(start), .x(x_in), .e(e_in),
      .busy(busy), .done(done), .y(y),
      .mm_a(mm_a), .mm_b(mm_b), .mm_rst(mm_rst),
      .mm_out(mm_out), .mm_done(mm_done)
   );

   always #5 clk = ~clk;

   function automatic logic [254:0] mulmod(input logic [254:0] a, input logic [254:0] b);
      logic [511:0] t;
      t = {257'd0, a} * {257'd0, b};
      t = t % {257'd0, P};
      return t[254:0];
   endfunction

   function automatic logic [254:0] powmod(input logic [254:0] b, input logic [254:0] ev);
      logic [254:0] r, base;
      r = 255'd1;
      base = b;
      for (int k = 0; k < 255; k++) begin
         if (ev[k]) r = mulmod(r, base);
         base = mulmod(base, base);
      end
      return r;
   endfunction

   function automatic logic [254:0] rand_fe();
      logic [255:0] t;
      for (int k = 0; k < 8; k++) t[k*32 +: 32] = $urandom;
      if (t[254:0] >= P) return t[254:0] - P;
      return t[254:0];
   endfunction

   // Multiplier result a*b*R^-1 mod p; small values are sometimes returned
   // as value+p, which the multiplier is allowed to do.
   function automatic logic [254:0] mont(input logic [254:0] a, input logic [254:0] b);
      logic [254:0] r;
      r = mulmod(mulmod(a, b), rinv);
      if (r < 255'd19 && $urandom_range(1, 0) == 1) r = r + P;
      return r;
   endfunction

   function automatic int exp_mults(input logic [254:0] ev);
`ifdef MONT_EXP_CT_EN
      return 2 + 2 * 255;
`else
      return 2 + 255 + $countones(ev);
`endif
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
      end
   endtask

   task automatic finish_up();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   endtask

   // Behavioural multiplier: operands captured in the load cycle, must stay
   // stable during the wait, result delivered after a random delay.
   logic [254:0] cap_a, cap_b;
   int  cnt;
   bit  mm_busy = 1'b0;
   always @(negedge clk) begin
      mm_done = 1'b0;
      if (rst) begin
         mm_busy = 1'b0;
      end else if (mm_rst) begin
         if (busy) pulses++;
         cap_a = mm_a;
         cap_b = mm_b;
         mm_busy = 1'b1;
         if (long_left > 0) begin
            cnt = $urandom_range(300, 255);
            long_left--;
         end else begin
            cnt = $urandom_range(dmax, dmin);
         end
         // stray completion during load must be ignored by the sequencer
         if ($urandom_range(3, 0) == 0) begin
            mm_done = 1'b1;
            mm_out = rand_fe();
         end
      end else if (mm_busy) begin
         check("mm_a_stable", {1'b0, mm_a}, {1'b0, cap_a});
         check("mm_b_stable", {1'b0, mm_b}, {1'b0, cap_b});
         cnt--;
         if (cnt == 0) begin
            mm_busy = 1'b0;
            mm_done = 1'b1;
            mm_out = mont(cap_a, cap_b);
         end
      end
   end

   // One exponentiation; call positioned at a negedge, returns at a negedge
   // where a new start may be issued right away.
   task automatic run(input logic [254:0] xv, input logic [254:0] ev,
                      input int glitch, output int cyc);
      logic [254:0] exp_y;
      bit seen;
      exp_y = powmod(xv, ev);
      x_in = xv;
      e_in = ev;
      start = 1'b1;
      pulses = 0;
      cyc = 0;
      seen = 1'b0;
      while (!seen && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) check("busy_after_start", {255'd0, busy}, 256'd1);
         if (done) seen = 1'b1;
         if (cyc == glitch) begin
            start = 1'b1;
            x_in = rand_fe();
            e_in = rand_fe();
         end else begin
            start = 1'b0;
         end
      end
      check("done_seen", {255'd0, seen}, 256'd1);
      if (!seen) finish_up();
      check("y", {1'b0, y}, {1'b0, exp_y});
      check("busy_at_done", {255'd0, busy}, 256'd0);
      check("mm_pulses", pulses, exp_mults(ev));
      @(negedge clk);
      check("done_single", {255'd0, done}, 256'd0);
      check("y_held", {1'b0, y}, {1'b0, exp_y});
   endtask

   initial begin
      int cyc_a, cyc_b, ndone;
      logic [254:0] inv2;
      rinv = powmod(255'd19, P - 255'd2);
      inv2 = (255'd1 << 254) - 255'd9;
      rst = 1'b1;
      start = 1'b0;
      x_in = '0;
      e_in = '0;
      mm_done = 1'b0;
      mm_out = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", {255'd0, busy}, 256'd0);
      check("rst_done", {255'd0, done}, 256'd0);
      check("rst_y", {1'b0, y}, 256'd0);
      check("rst_mm_a", {1'b0, mm_a}, 256'd0);
      check("rst_mm_b", {1'b0, mm_b}, 256'd0);
      check("rst_mm_rst", {255'd0, mm_rst}, 256'd1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // directed values
      run(255'd2, 255'd5, 0, cyc_a);
      check("pow2_5", {1'b0, y}, 256'd32);
      run(255'd2, P - 255'd2, 0, cyc_a);
      check("inv2_value", {1'b0, y}, {1'b0, inv2});
      check("inv2_times2", {1'b0, mulmod(y, 255'd2)}, 256'd1);
      run(255'd3, 255'd0, 0, cyc_a);
      check("e0_one", {1'b0, y}, 256'd1);
      run(255'd0, 255'd0, 0, cyc_a);
      check("x0_e0_one", {1'b0, y}, 256'd1);
      run(255'd0, 255'd7, 0, cyc_a);
      check("x0_zero", {1'b0, y}, 256'd0);
      run(P - 255'd1, 255'd2, 0, cyc_a);
      check("pm1_sq", {1'b0, y}, 256'd1);

      // fixed latency: every multiply takes d+1 cycles, NEXT one cycle each
      dmin = 2;
      dmax = 2;
      run(255'd2, 255'd5, 0, cyc_a);
      check("cycles_e5", cyc_a, exp_mults(255'd5) * 3 + 255 + 2);
      run(255'd2, P - 255'd2, 0, cyc_b);
      check("cycles_pm2", cyc_b, exp_mults(P - 255'd2) * 3 + 255 + 2);
`ifdef MONT_EXP_CT_EN
      check("ct_equal_cycles", cyc_a, cyc_b);
`endif
      dmin = 1;
      dmax = 4;

      // start pulsed mid-run with different operands is ignored
      run(rand_fe(), rand_fe(), 50, cyc_a);

      // reset while squaring aborts with no done
      dmin = 20;
      dmax = 20;
      x_in = rand_fe();
      e_in = rand_fe();
      start = 1'b1;
      pulses = 0;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 200 && pulses < 2; k++) @(negedge clk);
      check("reach_sqr", pulses, 2);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", {255'd0, busy}, 256'd0);
      check("abort_done", {255'd0, done}, 256'd0);
      check("abort_y", {1'b0, y}, 256'd0);
      check("abort_mm_a", {1'b0, mm_a}, 256'd0);
      check("abort_mm_b", {1'b0, mm_b}, 256'd0);
      check("abort_mm_rst", {255'd0, mm_rst}, 256'd1);
      dmin = 1;
      dmax = 4;
      ndone = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) ndone++;
      end
      rst = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("abort_no_done", ndone, 0);
      run(rand_fe(), rand_fe(), 0, cyc_a);

      // a few very slow multiplies
      long_left = 4;
      run(rand_fe(), rand_fe(), 0, cyc_a);

      // random operands
      repeat (2) run(rand_fe(), rand_fe(), 0, cyc_a);

      finish_up();
   end

endmodule

// File: doc/fe_mont_exp.md
Name: fe_mont_exp

Overview:
- Sequencer that computes y = x^e mod p, with p = 2^255 - 19.
- Uses square-and-multiply in the Montgomery domain (R = 2^255).
- Sits directly upstream and downstream of the team's radix-2 Montgomery multiplier (mm_*). It drives the multiplier's a/b/rst inputs and consumes its out/done.
- Used for field inversion (e = p-2) and general exponentiation in the curve datapath.

Parameters:
- EXP_W, 255: exponent width in bits. Bits are scanned MSB first.
- FE_W, 255: field element width. Fixed by p; do not override.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request. Sampled only in IDLE.
- x  in  FE_W  base. Must be < p. Latched on accepted start.
- e  in  EXP_W  exponent. Latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when y becomes valid.
- y  out  FE_W  result, fully reduced (< p). Held until the next accepted start.
- mm_a  out  FE_W  multiplier operand a. Registered.
- mm_b  out  FE_W  multiplier operand b. Registered.
- mm_rst  out  1  multiplier load/reset strobe.
- mm_out  in  FE_W  multiplier result a*b*2^-255 mod p.
- mm_done  in  1  multiplier completion. Single-cycle pulse.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, y=0, mm_a=0, mm_b=0.
  - mm_rst=1 while rst is high, so the multiplier is held in reset.
  - Internal registers cleared. An aborted operation produces no done.
- Multiplier handshake, MM(a,b):
  - LOAD cycle: mm_a/mm_b driven, mm_rst=1 for exactly one cycle.
  - WAIT: mm_rst=0; mm_a/mm_b held stable, because the multiplier reads b every cycle.
  - mm_done is ignored in the LOAD cycle.
  - On the first WAIT cycle with mm_done=1, capture mm_out into the target register and advance.
  - No internal timeout; the controller waits indefinitely.
- Constants:
  - ONE_M = R mod p = 19.
  - R2 = R^2 mod p = 361.
- States and transitions:
  - IDLE: start=1 latches x and e, sets acc=ONE_M, bit index i=EXP_W-1 -> TOM.
  - TOM: xm = MM(x, R2) -> SQR.
  - SQR: acc = MM(acc, acc). If e[i]=1 -> MUL; else -> NEXT.
  - MUL: acc = MM(acc, xm) -> NEXT.
  - NEXT: if i==0 -> FROM; else i=i-1 -> SQR. This state takes one cycle.
  - FROM: r = MM(acc, 1).
  - FIN: if r >= p then y = r - p, else y = r. Assert done for one cycle, drop busy -> IDLE.
- start asserted while not in IDLE is ignored; latched x/e are unaffected.
- Total multiplications = 2 + EXP_W + popcount(e).
- e=0 gives y=1, including when x=0. x=0 with e>0 gives y=0.
- done and a new start may occur in consecutive cycles. start in the cycle after done is accepted.

Optional Feature:
- MONT_EXP_CT_EN defined (constant-time ladder):
  - The MUL step runs for every bit. Its result is written to acc only when e[i]=1; otherwise it goes to a dummy register.
  - Multiplication count = 2 + 2*EXP_W, independent of e.
  - mm_a/mm_b/mm_rst sequence timing is identical for all e.
- MONT_EXP_CT_EN undefined: MUL is skipped for zero bits, as described above.

Test Plan:
- x=2, e=5, EXP_W=255, macro off -> y=32, one done pulse. Count exactly 259 mm_rst pulses outside reset.
- x=2, e=p-2 -> y = 0x3FFF...FFF7 (2^254-9, the inverse of 2). Check y*2 mod p = 1.
- x=3, e=0 -> y=1. x=0, e=7 -> y=0. x=p-1, e=2 -> y=1.
- MONT_EXP_CT_EN on:
  - e=5 and e=p-2 both yield exactly 512 mm_rst pulses and identical cycle counts start-to-done.
  - Results are unchanged from the macro-off runs.
- start pulsed mid-run with a different x: ignored, original result produced. rst asserted during SQR: outputs zero immediately, mm_rst=1, no done. After release, a new start completes correctly.
- Multiplier model with a randomly delayed mm_done (255..300 cycles): mm_a/mm_b stay stable throughout each WAIT, and the result is still correct.
